// File: rtl/pong_pkg.sv
// Shared playfield geometry and ball state encoding for the pong blocks.
// The ball motion, bar renderer and ball renderer all size themselves from these.
package pong_pkg;

    localparam int CELL_PX = 10;
    localparam int COLS    = 64;
    localparam int ROWS    = 48;
    localparam int BAR_ROW = 46;
    localparam int BAR_W   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOST = 2'd2
    } ball_state_e;

endpackage

// File: rtl/move_tick_div.sv
// Frame-tick divider: emits a step strobe on every MOVE_DIV-th enabled frame tick.
// The strobe is combinational so the ball position registers one clk after the tick.
module move_tick_div #(
    parameter int MOVE_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_tick,
    output logic o_step
);

    logic [3:0] r_cnt;
    logic       w_last;

    assign w_last = (r_cnt == 4'(MOVE_DIV - 1));
    assign o_step = i_en & i_tick & w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_en && i_tick) begin
            r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Ball position/direction state machine: serve, wall and bar reflections, miss detection.
// States: IDLE = parked at serve cell | RUN = moving | LOST = frozen after a miss.
module ball_motion #(
    parameter int COLS     = pong_pkg::COLS,
    parameter int ROWS     = pong_pkg::ROWS,
    parameter int BAR_ROW  = pong_pkg::BAR_ROW,
    parameter int BAR_W    = pong_pkg::BAR_W,
    parameter int MOVE_DIV = 4,
    parameter int SERVE_X  = 32,
    parameter int SERVE_Y  = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [6:0] bar_x,
    output logic [6:0] ball_x,
    output logic [6:0] ball_y,
    output logic       hit,
    output logic       miss,
    output logic [7:0] hit_count
);

    import pong_pkg::*;

    ball_state_e r_state;
    logic [6:0]  r_x;
    logic [6:0]  r_y;
    logic        r_dx;
    logic        r_dy;
    logic        r_hit;
    logic        r_miss;
    logic [7:0]  r_hit_count;

    logic        w_step;
    logic        w_serve_ok;
    logic        w_dx_n;
    logic        w_dy_n;
    logic        w_bar_hit;
    logic [7:0]  w_bar_end;
    logic [6:0]  w_x_n;
    logic [6:0]  w_y_n;

    assign w_serve_ok = serve & (r_state != RUN);

    move_tick_div #(
        .MOVE_DIV (MOVE_DIV)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_serve_ok),
        .i_en   (r_state == RUN),
        .i_tick (frame_tick),
        .o_step (w_step)
    );

    // dx/dy: 1 = +1, 0 = -1. Bar span is 8 bits so bar_x near 127 cannot wrap.
    assign w_bar_end = {1'b0, bar_x} + 8'(BAR_W);
    assign w_bar_hit = r_dy && (r_y == 7'(BAR_ROW - 1))
                       && ({1'b0, r_x} >= {1'b0, bar_x})
                       && ({1'b0, r_x} < w_bar_end);

    always_comb begin
        w_dx_n = r_dx;
        if (r_dx && (r_x == 7'(COLS - 1))) begin
            w_dx_n = 1'b0;
        end else if (!r_dx && (r_x == 7'd0)) begin
            w_dx_n = 1'b1;
        end

        w_dy_n = r_dy;
        if (!r_dy && (r_y == 7'd0)) begin
            w_dy_n = 1'b1;
        end else if (w_bar_hit) begin
            w_dy_n = 1'b0;
        end

        w_x_n = w_dx_n ? r_x + 7'd1 : r_x - 7'd1;
        w_y_n = w_dy_n ? r_y + 7'd1 : r_y - 7'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_x         <= 7'(SERVE_X);
            r_y         <= 7'(SERVE_Y);
            r_dx        <= 1'b1;
            r_dy        <= 1'b1;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
            r_hit_count <= 8'd0;
        end else begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
            case (r_state)
                IDLE, LOST: begin
                    if (serve) begin
                        r_x     <= 7'(SERVE_X);
                        r_y     <= 7'(SERVE_Y);
                        r_dx    <= 1'b1;
                        r_dy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_step) begin
                        r_x   <= w_x_n;
                        r_y   <= w_y_n;
                        r_dx  <= w_dx_n;
                        r_dy  <= w_dy_n;
                        r_hit <= w_bar_hit;
                        if (w_bar_hit && (r_hit_count != 8'hFF)) begin
                            r_hit_count <= r_hit_count + 8'd1;
                        end
                        if (w_y_n == 7'(ROWS - 1)) begin
                            r_miss  <= 1'b1;
                            r_state <= LOST;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ball_x    = r_x;
    assign ball_y    = r_y;
    assign hit       = r_hit;
    assign miss      = r_miss;
    assign hit_count = r_hit_count;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: reference model feeds a scoreboard queue, popped after each clk.
// A second, shortened-playfield instance drives the hit counter into saturation quickly.
module tb_ball_motion;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick = 1'b0;
    logic       serve = 1'b0;
    logic [6:0] bar_x = 7'd0;
    logic [6:0] ball_x;
    logic [6:0] ball_y;
    logic       hit;
    logic       miss;
    logic [7:0] hit_count;

    logic       tick_s = 1'b0;
    logic       serve_s = 1'b0;
    logic [6:0] bar_x_s;
    logic [6:0] ball_x_s;
    logic [6:0] ball_y_s;
    logic       hit_s;
    logic       miss_s;
    logic [7:0] hit_count_s;

    always #5 clk = ~clk;

    ball_motion u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .serve      (serve),
        .bar_x      (bar_x),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .hit        (hit),
        .miss       (miss),
        .hit_count  (hit_count)
    );

    // Short field, step every tick, bar always under the ball: a hit every 10 steps.
    ball_motion #(
        .ROWS     (8),
        .BAR_ROW  (6),
        .MOVE_DIV (1),
        .SERVE_Y  (2)
    ) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (tick_s),
        .serve      (serve_s),
        .bar_x      (bar_x_s),
        .ball_x     (ball_x_s),
        .ball_y     (ball_y_s),
        .hit        (hit_s),
        .miss       (miss_s),
        .hit_count  (hit_count_s)
    );

    assign bar_x_s = (ball_x_s >= 7'd2) ? ball_x_s - 7'd2 : 7'd0;

    typedef struct packed {
        logic [6:0] x;
        logic [6:0] y;
        logic       h;
        logic       m;
        logic [7:0] hc;
    } obs_t;

    obs_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: state 0 idle, 1 run, 2 lost; directions as +1/-1.
    int mx, my, mdx, mdy, mdiv, mst, mhc;
    bit mh, mm;

    task automatic m_reset();
        mx = 32; my = 24; mdx = 1; mdy = 1; mdiv = 0; mst = 0; mhc = 0; mh = 0; mm = 0;
    endtask

    task automatic m_step();
        bit bh;
        bh = 0;
        if ((mx == 63 && mdx == 1) || (mx == 0 && mdx == -1)) mdx = -mdx;
        if (my == 0 && mdy == -1) mdy = 1;
        else if (my == 45 && mdy == 1 && mx >= int'(bar_x) && mx < int'(bar_x) + 6) begin
            mdy = -1;
            bh = 1;
        end
        mx = mx + mdx;
        my = my + mdy;
        mh = bh;
        if (bh && mhc < 255) mhc++;
        if (my == 47) begin
            mm = 1;
            mst = 2;
        end
    endtask

    task automatic m_cycle(input bit t, input bit s);
        mh = 0;
        mm = 0;
        if (mst != 1) begin
            if (s) begin
                mx = 32; my = 24; mdx = 1; mdy = 1; mdiv = 0; mst = 1;
            end
        end else if (t) begin
            if (mdiv == 3) begin
                mdiv = 0;
                m_step();
            end else begin
                mdiv++;
            end
        end
    endtask

    task automatic push_model();
        obs_t e;
        e.x = 7'(mx); e.y = 7'(my); e.h = mh; e.m = mm; e.hc = 8'(mhc);
        sb.push_back(e);
    endtask

    task automatic check_obs(input string tag);
        obs_t got, exp;
        got = {ball_x, ball_y, hit, miss, hit_count};
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = sb.pop_front();
            assert (got === exp) else begin
                fails++;
                $error("FAIL %s: got x=%0d y=%0d hit=%0b miss=%0b hc=%0d, expected x=%0d y=%0d hit=%0b miss=%0b hc=%0d",
                       tag, got.x, got.y, got.h, got.m, got.hc, exp.x, exp.y, exp.h, exp.m, exp.hc);
            end
        end
    endtask

    task automatic cycle(input bit t, input bit s, input string tag);
        @(negedge clk);
        frame_tick = t;
        serve = s;
        m_cycle(t, s);
        push_model();
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        serve = 1'b0;
        check_obs(tag);
    endtask

    task automatic run_to_bar(input string tag);
        int n;
        n = 0;
        while (!(mst == 1 && my == 45 && mdy == 1) && n < 1000) begin
            cycle(1'b1, 1'b0, tag);
            n++;
        end
        tests++;
        assert (n < 1000) else begin
            fails++;
            $error("FAIL %s: ball never reached bar row, got %0d ticks, expected < 1000", tag, n);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int pulses;
        rst_n = 1'b1;
        m_reset();
        #2 rst_n = 1'b0;
        #10;
        push_model();
        check_obs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        repeat (2) cycle(1'b1, 1'b0, "idle_tick");
        cycle(1'b1, 1'b1, "serve");
        cycle(1'b0, 1'b0, "no_tick");
        repeat (4) cycle(1'b1, 1'b0, "first_step");

        run_to_bar("run1");
        bar_x = 7'(mx);
        repeat (4) cycle(1'b1, 1'b0, "hit_left_edge");
        cycle(1'b1, 1'b0, "hit_clear");

        run_to_bar("run2");
        bar_x = (mx >= 5) ? 7'(mx - 5) : 7'(mx);
        repeat (4) cycle(1'b1, 1'b0, "hit_right_edge");

        run_to_bar("run3");
        bar_x = (mx >= 6) ? 7'(mx - 6) : 7'(mx + 1);
        repeat (8) cycle(1'b1, 1'b0, "miss");
        repeat (8) cycle(1'b1, 1'b0, "lost_hold");

        cycle(1'b1, 1'b1, "reserve");
        repeat (4) cycle(1'b1, 1'b0, "after_reserve");
        repeat (4) cycle(1'b1, 1'b1, "serve_in_run");
        repeat (12) cycle(1'b1, 1'b0, "run_more");

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        push_model();
        check_obs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) cycle(1'b1, 1'b0, "post_reset_idle");
        cycle(1'b1, 1'b1, "serve_after_reset");
        repeat (4) cycle(1'b1, 1'b0, "step_after_reset");

        @(negedge clk);
        serve_s = 1'b1;
        @(negedge clk);
        serve_s = 1'b0;
        tick_s = 1'b1;
        pulses = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (hit_s) begin
                pulses++;
                if (pulses == 100) check8("hc_at_100", hit_count_s, 8'd100);
            end
        end
        tests++;
        assert (pulses >= 256) else begin
            fails++;
            $error("FAIL sat_pulses: got %0d hit pulses, expected >= 256", pulses);
        end
        check8("hc_saturated", hit_count_s, 8'd255);
        repeat (100) @(posedge clk);
        #1;
        check8("hc_stays_255", hit_count_s, 8'd255);
        check8("sat_no_miss", {7'd0, miss_s}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
